// File: rtl/sha256_miner_pkg.sv
// sha256_miner_pkg
// Shared types and constants for the double SHA-256 nonce sequencer:
//   state_t   - controller FSM states
//   blk_t     - which of the three compressions is in flight
//   PAD_WORD / LEN_B2 / LEN_B3 - SHA-256 padding and message-length words
package sha256_miner_pkg;

    localparam int HDR_WORDS = 19;              // header words excluding the nonce
    localparam int HDR_W     = HDR_WORDS * 32;  // 608 bits

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_B2   = 32'h0000_0280;  // 640-bit header message
    localparam logic [31:0] LEN_B3   = 32'h0000_0100;  // 256-bit digest message

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_START,
        S_WAIT,
        S_LATCH,
        S_CMP,
        S_REPORT,
        S_NEXT
    } state_t;

    // B1/B2: first and second block of the header hash, B3: hash of digest1.
    typedef enum logic [1:0] {
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } blk_t;

endpackage

// File: rtl/sha256_block_mux.sv
// sha256_block_mux
// Combinational message builder for the three compressions of a double
// SHA-256 over an 80-byte header.
// Ports:
//   blk     in  blk_t   - which block to build
//   header  in  608     - header words 0..18, word j at [32j+31:32j]
//   nonce   in  32      - candidate nonce (header word 19)
//   digest1 in  256     - first-pass digest, H0 at [255:224]
//   msg     out 512     - message, W[i] at [32i+31:32i]
module sha256_block_mux
    import sha256_miner_pkg::*;
(
    input  blk_t               blk,
    input  logic [HDR_W-1:0]   header,
    input  logic [31:0]        nonce,
    input  logic [255:0]       digest1,
    output logic [511:0]       msg
);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            logic [31:0] w_b1;
            logic [31:0] w_b2;
            logic [31:0] w_b3;

            assign w_b1 = header[32*gi +: 32];

            // Second block: tail of the header, nonce, then padding for 640 bits.
            if (gi < 3) begin : g_b2_hdr
                assign w_b2 = header[32*(16+gi) +: 32];
            end else if (gi == 3) begin : g_b2_nonce
                assign w_b2 = nonce;
            end else if (gi == 4) begin : g_b2_pad
                assign w_b2 = PAD_WORD;
            end else if (gi == 15) begin : g_b2_len
                assign w_b2 = LEN_B2;
            end else begin : g_b2_zero
                assign w_b2 = 32'h0;
            end

            // Third block: digest1 word-for-word (H0 first), padding for 256 bits.
            if (gi < 8) begin : g_b3_dig
                assign w_b3 = digest1[255-32*gi -: 32];
            end else if (gi == 8) begin : g_b3_pad
                assign w_b3 = PAD_WORD;
            end else if (gi == 15) begin : g_b3_len
                assign w_b3 = LEN_B3;
            end else begin : g_b3_zero
                assign w_b3 = 32'h0;
            end

            assign msg[32*gi +: 32] = (blk == B2) ? w_b2 :
                                      (blk == B3) ? w_b3 : w_b1;
        end
    endgenerate

endmodule

// File: rtl/sha256_miner_ctrl.sv
// sha256_miner_ctrl
// Drives one SHA-256 compression core through a double SHA-256 of an
// 80-byte block header for every nonce in [nonce_start, nonce_end]
// (inclusive, wrapping through 0xFFFFFFFF) and reports each nonce whose
// final digest is <= target.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   cfg_valid/cfg_ready + cfg_*   - job offer (header, nonce range, target)
//   abort                         - cancel the running job
//   core_reset/core_start/core_data_in, core_data_out/core_done - core link
//   found_valid/found_ready, found_nonce, found_hash - result stream
//   busy, exhausted, tried_count  - status
module sha256_miner_ctrl
    import sha256_miner_pkg::*;
#(
    parameter int NONCE_W = 32
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [HDR_W-1:0]   cfg_header,
    input  logic [NONCE_W-1:0] cfg_nonce_start,
    input  logic [NONCE_W-1:0] cfg_nonce_end,
    input  logic [255:0]       cfg_target,
    input  logic               abort,
    output logic               core_reset,
    output logic               core_start,
    output logic [511:0]       core_data_in,
    input  logic [255:0]       core_data_out,
    input  logic               core_done,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [255:0]       found_hash,
    output logic               busy,
    output logic               exhausted,
    output logic [31:0]        tried_count
);

    state_t               state_reg;
    blk_t                 blk_reg;
    logic [HDR_W-1:0]     header_reg;
    logic [NONCE_W-1:0]   nonce_reg;
    logic [NONCE_W-1:0]   nonce_end_reg;
    logic [255:0]         target_reg;
    logic [255:0]         digest1_reg;
    logic [255:0]         digest2_reg;
    logic                 core_reset_reg;
    logic                 core_start_reg;
    logic [511:0]         core_data_in_reg;
    logic                 found_valid_reg;
    logic [NONCE_W-1:0]   found_nonce_reg;
    logic [255:0]         found_hash_reg;
    logic                 exhausted_reg;
    logic [31:0]          tried_count_reg;

    blk_t                 mux_blk;
    logic [511:0]         block_msg;

    // The message is registered on entry to START. LATCH of B1 moves straight
    // to START for B2, so the mux must already look at the upcoming block;
    // every other entry to START comes from INIT where blk_reg is current.
    assign mux_blk = (state_reg == S_LATCH) ? B2 : blk_reg;

    sha256_block_mux u_block_mux (
        .blk     (mux_blk),
        .header  (header_reg),
        .nonce   (nonce_reg),
        .digest1 (digest1_reg),
        .msg     (block_msg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_IDLE;
            blk_reg          <= B1;
            header_reg       <= '0;
            nonce_reg        <= '0;
            nonce_end_reg    <= '0;
            target_reg       <= '0;
            digest1_reg      <= '0;
            digest2_reg      <= '0;
            core_reset_reg   <= 1'b1;  // keeps the core at IV while in reset
            core_start_reg   <= 1'b0;
            core_data_in_reg <= '0;
            found_valid_reg  <= 1'b0;
            found_nonce_reg  <= '0;
            found_hash_reg   <= '0;
            exhausted_reg    <= 1'b0;
            tried_count_reg  <= '0;
        end else begin
            // Single-cycle strobes default low.
            core_reset_reg <= 1'b0;
            core_start_reg <= 1'b0;
            exhausted_reg  <= 1'b0;

            if (abort && state_reg != S_IDLE) begin
                // Cancel: park the core at IV, drop any pending result,
                // keep tried_count for the host to read.
                state_reg       <= S_IDLE;
                core_reset_reg  <= 1'b1;
                found_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (cfg_valid) begin
                            header_reg      <= cfg_header;
                            nonce_reg       <= cfg_nonce_start;
                            nonce_end_reg   <= cfg_nonce_end;
                            target_reg      <= cfg_target;
                            tried_count_reg <= '0;
                            blk_reg         <= B1;
                            core_reset_reg  <= 1'b1;
                            state_reg       <= S_INIT;
                        end
                    end

                    S_INIT: begin
                        core_start_reg   <= 1'b1;
                        core_data_in_reg <= block_msg;
                        state_reg        <= S_START;
                    end

                    S_START: begin
                        state_reg <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (core_done) begin
                            state_reg <= S_LATCH;
                        end
                    end

                    S_LATCH: begin
                        case (blk_reg)
                            B1: begin
                                // Second header block chains from the first.
                                blk_reg          <= B2;
                                core_start_reg   <= 1'b1;
                                core_data_in_reg <= block_msg;
                                state_reg        <= S_START;
                            end
                            B2: begin
                                // Second hash starts fresh from IV.
                                digest1_reg    <= core_data_out;
                                blk_reg        <= B3;
                                core_reset_reg <= 1'b1;
                                state_reg      <= S_INIT;
                            end
                            default: begin
                                digest2_reg <= core_data_out;
                                state_reg   <= S_CMP;
                            end
                        endcase
                    end

                    S_CMP: begin
                        if (digest2_reg <= target_reg) begin
                            found_valid_reg <= 1'b1;
                            found_nonce_reg <= nonce_reg;
                            found_hash_reg  <= digest2_reg;
                            state_reg       <= S_REPORT;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end

                    S_REPORT: begin
                        if (found_ready) begin
                            found_valid_reg <= 1'b0;
                            state_reg       <= S_NEXT;
                        end
                    end

                    S_NEXT: begin
                        tried_count_reg <= tried_count_reg + 32'd1;
                        if (nonce_reg == nonce_end_reg) begin
                            exhausted_reg <= 1'b1;
                            state_reg     <= S_IDLE;
                        end else begin
                            // Natural 32-bit wrap lets end < start sweep through zero.
                            nonce_reg      <= nonce_reg + 1'b1;
                            blk_reg        <= B1;
                            core_reset_reg <= 1'b1;
                            state_reg      <= S_INIT;
                        end
                    end

                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_ready    = (state_reg == S_IDLE);
    assign busy         = (state_reg != S_IDLE);
    assign core_reset   = core_reset_reg;
    assign core_start   = core_start_reg;
    assign core_data_in = core_data_in_reg;
    assign found_valid  = found_valid_reg;
    assign found_nonce  = found_nonce_reg;
    assign found_hash   = found_hash_reg;
    assign exhausted    = exhausted_reg;
    assign tried_count  = tried_count_reg;

endmodule

// File: tb/tb_sha256_miner_ctrl.sv
// tb_sha256_miner_ctrl
// Bench for sha256_miner_ctrl with a behavioural SHA-256 core attached.
// Jobs push expected (nonce, digest) results and the expected tried_count
// into queues; a negedge monitor pops and compares on every found handshake
// and every exhausted pulse.
module tb_sha256_miner_ctrl;

    localparam int TCORE = 4;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [607:0]   cfg_header = '0;
    logic [31:0]    cfg_nonce_start = '0;
    logic [31:0]    cfg_nonce_end = '0;
    logic [255:0]   cfg_target = '0;
    logic           abort = 1'b0;
    logic           core_reset;
    logic           core_start;
    logic [511:0]   core_data_in;
    logic [255:0]   core_data_out;
    logic           core_done;
    logic           found_valid;
    logic           found_ready = 1'b1;
    logic [31:0]    found_nonce;
    logic [255:0]   found_hash;
    logic           busy;
    logic           exhausted;
    logic [31:0]    tried_count;

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_nonce_q [$];
    logic [255:0] exp_hash_q  [$];
    logic [31:0]  exp_tried_q [$];

    always #5 clk = ~clk;

    sha256_miner_ctrl #(.NONCE_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_header      (cfg_header),
        .cfg_nonce_start (cfg_nonce_start),
        .cfg_nonce_end   (cfg_nonce_end),
        .cfg_target      (cfg_target),
        .abort           (abort),
        .core_reset      (core_reset),
        .core_start      (core_start),
        .core_data_in    (core_data_in),
        .core_data_out   (core_data_out),
        .core_done       (core_done),
        .found_valid     (found_valid),
        .found_ready     (found_ready),
        .found_nonce     (found_nonce),
        .found_hash      (found_hash),
        .busy            (busy),
        .exhausted       (exhausted),
        .tried_count     (tried_count)
    );

    // ---------------- reference SHA-256 ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = h_in;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
                h_in[127:96] + e, h_in[95:64] + f, h_in[63:32] + g, h_in[31:0] + h};
    endfunction

    // Double SHA-256 of the 80-byte header with the nonce as word 19.
    function automatic logic [255:0] double_sha(input logic [607:0] hdr, input logic [31:0] nonce);
        logic [511:0] b1, b2, b3;
        logic [255:0] d1;
        b1 = hdr[511:0];
        b2 = '0;
        b2[95:0]    = hdr[607:512];
        b2[127:96]  = nonce;
        b2[159:128] = 32'h80000000;
        b2[511:480] = 32'h00000280;
        d1 = sha_compress(sha_compress(IV, b1), b2);
        b3 = '0;
        for (int i = 0; i < 8; i++) b3[32*i +: 32] = d1[255-32*i -: 32];
        b3[287:256] = 32'h80000000;
        b3[511:480] = 32'h00000100;
        return sha_compress(IV, b3);
    endfunction

    function automatic logic [607:0] make_hdr(input logic [31:0] seed);
        logic [607:0] hv;
        for (int j = 0; j < 19; j++) hv[32*j +: 32] = seed ^ (32'h9e3779b9 * 32'(j + 1));
        return hv;
    endfunction

    // ---------------- behavioural core ----------------
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    logic [255:0] core_h = '0;
    logic [511:0] core_blk = '0;
    logic         core_done_r = 1'b0;

    always @(posedge clk) begin
        if (core_reset) begin
            core_h      <= IV;
            core_busy   <= 1'b0;
            core_done_r <= 1'b0;
            core_cnt    <= 0;
        end else begin
            core_done_r <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 1) begin
                    core_h      <= sha_compress(core_h, core_blk);
                    core_done_r <= 1'b1;
                    core_busy   <= 1'b0;
                end
                core_cnt <= core_cnt - 1;
            end else if (core_start) begin
                core_busy <= 1'b1;
                core_cnt  <= TCORE;
                core_blk  <= core_data_in;
            end
        end
    end

    assign core_data_out = core_h;
    assign core_done     = core_done_r;

    // ---------------- monitor / scoreboard ----------------
    logic         pend = 1'b0;
    logic [31:0]  pend_nonce = '0;
    logic [255:0] pend_hash = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (core_busy && !core_reset) begin
                checks++;
                if (core_data_in !== core_blk) begin
                    errors++;
                    $display("FAIL core_data_hold: got %h required %h", core_data_in, core_blk);
                end
            end
            if (core_start) begin
                checks++;
                if (core_busy) begin
                    errors++;
                    $display("FAIL core_start_while_busy: got start=1 required start=0");
                end
            end
            if (pend) begin
                checks++;
                if (found_valid !== 1'b1 || found_nonce !== pend_nonce || found_hash !== pend_hash) begin
                    errors++;
                    $display("FAIL found_hold: got v=%b n=%h required v=1 n=%h", found_valid, found_nonce, pend_nonce);
                end
            end
            if (found_valid && !found_ready) begin
                checks++;
                if (core_start !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_start: got core_start=%b required 0", core_start);
                end
            end
            if (found_valid && found_ready) begin
                checks++;
                if (exp_nonce_q.size() == 0) begin
                    errors++;
                    $display("FAIL found_unexpected: got nonce %h required none", found_nonce);
                end else begin
                    logic [31:0]  en;
                    logic [255:0] eh;
                    en = exp_nonce_q.pop_front();
                    eh = exp_hash_q.pop_front();
                    $display("found nonce=%h hash=%h", found_nonce, found_hash);
                    if (found_nonce !== en) begin
                        errors++;
                        $display("FAIL found_nonce: got %h required %h", found_nonce, en);
                    end
                    checks++;
                    if (found_hash !== eh) begin
                        errors++;
                        $display("FAIL found_hash: got %h required %h", found_hash, eh);
                    end
                end
            end
            pend       = found_valid && !found_ready;
            pend_nonce = found_nonce;
            pend_hash  = found_hash;
            if (exhausted) begin
                checks++;
                if (exp_tried_q.size() == 0) begin
                    errors++;
                    $display("FAIL exhausted_unexpected: got pulse tried=%0d required none", tried_count);
                end else begin
                    logic [31:0] et;
                    et = exp_tried_q.pop_front();
                    $display("exhausted tried_count=%0d", tried_count);
                    if (tried_count !== et) begin
                        errors++;
                        $display("FAIL tried_count: got %0d required %0d", tried_count, et);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chk1("rst_core_reset", core_reset, 1'b1);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_found_valid", found_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_exhausted", exhausted, 1'b0);
        chk32("rst_found_nonce", found_nonce, 32'h0);
        chk256("rst_found_hash", found_hash, 256'h0);
        chk32("rst_tried_count", tried_count, 32'h0);
        chk1("rst_core_data_in", (core_data_in == 512'h0), 1'b1);
    endtask

    // Push the expected results of a job, then offer it.
    task automatic expect_job(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                              input logic [255:0] t);
        logic [31:0]  n;
        logic [255:0] d;
        int cnt;
        n = s;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            d = double_sha(hdr, n);
            cnt++;
            if (d <= t) begin
                exp_nonce_q.push_back(n);
                exp_hash_q.push_back(d);
            end
            if (n == e) break;
            n = n + 32'd1;
        end
        exp_tried_q.push_back(32'(cnt));
    endtask

    task automatic offer_job(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] t);
        $display("job start=%h end=%h target=%h", s, e, t);
        chk1("cfg_ready_before_offer", cfg_ready, 1'b1);
        cfg_header      = hdr;
        cfg_nonce_start = s;
        cfg_nonce_end   = e;
        cfg_target      = t;
        cfg_valid       = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk1("busy_after_accept", busy, 1'b1);
        chk1("cfg_ready_after_accept", cfg_ready, 1'b0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL job_timeout: got busy after %0d cycles required idle", max_cycles);
        end
        tick();
    endtask

    // Wait until core_start has been seen `count` times (bounded).
    task automatic wait_starts(input int count);
        int seen, n;
        seen = 0;
        n = 0;
        while (seen < count && n < 1000) begin
            tick();
            if (core_start) seen++;
            n++;
        end
        checks++;
        if (seen < count) begin
            errors++;
            $display("FAIL start_timeout: got %0d starts required %0d", seen, count);
        end
    endtask

    task automatic run_job(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                           input logic [255:0] t);
        expect_job(hdr, s, e, t);
        offer_job(hdr, s, e, t);
        wait_idle(3000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] abc_blk;
        int n;

        #2 reset_n = 1'b0;
        tick();
        tick();
        check_reset_values();

        // Sanity of the reference model against the well-known "abc" digest.
        abc_blk = '0;
        abc_blk[31:0]    = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
        chk256("ref_sha_abc", sha_compress(IV, abc_blk),
               256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        reset_n = 1'b1;
        tick();
        chk1("core_reset_after_release", core_reset, 1'b0);

        // All nonces qualify; three results then exhausted with tried=3.
        run_job(make_hdr(32'h01020304), 32'h5, 32'h7, '1);
        // Nothing qualifies.
        run_job(make_hdr(32'hcafef00d), 32'h10, 32'h13, '0);
        // Wrap through 0xFFFFFFFF.
        run_job(make_hdr(32'h5a5a0001), 32'hFFFFFFFE, 32'h1, '1);
        // Single-nonce range.
        run_job(make_hdr(32'h00c0ffee), 32'h77, 32'h77, '1);

        // Result stall: consumer holds found_ready low for 20 cycles.
        found_ready = 1'b0;
        expect_job(make_hdr(32'h13572468), 32'h20, 32'h21, '1);
        offer_job(make_hdr(32'h13572468), 32'h20, 32'h21, '1);
        n = 0;
        while (!found_valid && n < 500) begin
            tick();
            n++;
        end
        chk1("stall_found_valid", found_valid, 1'b1);
        repeat (20) tick();
        chk32("stall_tried_hold", tried_count, 32'h0);
        found_ready = 1'b1;
        tick();                              // handshake edge -> NEXT
        chk1("stall_found_drop", found_valid, 1'b0);
        tick();                              // NEXT -> INIT of next nonce
        chk1("stall_resume_reset", core_reset, 1'b1);
        chk32("stall_resume_tried", tried_count, 32'h1);
        wait_idle(3000);

        // Abort in WAIT of B2 for the second nonce (5th core start).
        offer_job(make_hdr(32'h0badbeef), 32'h30, 32'h31, '0);
        wait_starts(5);
        tick();                              // now in WAIT
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_cfg_ready", cfg_ready, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_core_reset", core_reset, 1'b1);
        chk32("abort_tried_hold", tried_count, 32'h1);
        tick();
        chk1("abort_core_reset_pulse", core_reset, 1'b0);
        chk32("abort_tried_hold2", tried_count, 32'h1);
        run_job(make_hdr(32'h11223344), 32'h40, 32'h41, '1);

        // Asynchronous reset mid-B3.
        offer_job(make_hdr(32'h99887766), 32'h50, 32'h51, '1);
        wait_starts(3);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_values();
        tick();
        reset_n = 1'b1;
        tick();
        chk1("core_reset_after_midjob_reset", core_reset, 1'b0);
        run_job(make_hdr(32'h2468ace0), 32'h60, 32'h62, '1);

        tick();
        chk32("found_queue_drained", 32'(exp_nonce_q.size()), 32'h0);
        chk32("exhausted_queue_drained", 32'(exp_tried_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion required finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
